// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  // Burst counter needs to hold 0..MAX_BURST-1, never narrower than one bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of the arbiter; slave = arbiter view, master = environment view.
interface ram_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_address, ram_in, ram_load
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_address, ram_in, ram_load
  );
endinterface

// File: rtl/ram_arb_rport.sv
// Per-requester read-return register: captures RAM data on the edge that ends a read beat.
module ram_arb_rport #(
  parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_en_i;
      if (rd_en_i) rdata_q <= rdata_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU (req 0) and DMA (req 1),
// with bounded bursts under contention and registered read return.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);
  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          beat0, beat1;

  assign beat0 = (state_q == G0) && bus.req0;
  assign beat1 = (state_q == G1) && bus.req1;

  always_comb begin
    bus.ram_address = '0;
    bus.ram_in      = '0;
    bus.ram_load    = 1'b0;
    if (beat0) begin
      bus.ram_address = bus.addr0;
      bus.ram_in      = bus.wdata0;
      bus.ram_load    = bus.we0 & rst_n;
    end else if (beat1) begin
      bus.ram_address = bus.addr1;
      bus.ram_in      = bus.wdata1;
      bus.ram_load    = bus.we1 & rst_n;
    end
  end

  assign bus.gnt0 = (state_q == G0);
  assign bus.gnt1 = (state_q == G1);

  // Tie from IDLE goes to whichever requester was not served last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || last_q)) begin
            state_q <= G0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (bus.req1) begin
            state_q <= G1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        G0: begin
          if (!bus.req0) begin
            state_q <= bus.req1 ? G1 : IDLE;
            last_q  <= bus.req1 ? 1'b1 : last_q;
            cnt_q   <= '0;
          end else if (bus.req1 && cnt_q == CNT_LAST) begin
            state_q <= G1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        G1: begin
          if (!bus.req1) begin
            state_q <= bus.req0 ? G0 : IDLE;
            last_q  <= bus.req0 ? 1'b0 : last_q;
            cnt_q   <= '0;
          end else if (bus.req0 && cnt_q == CNT_LAST) begin
            state_q <= G0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_arb_rport #(.DATA_W(DATA_W)) u_rport0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (beat0 & ~bus.we0),
    .rdata_i  (bus.ram_out),
    .rvalid_o (bus.rvalid0),
    .rdata_o  (bus.rdata0)
  );

  ram_arb_rport #(.DATA_W(DATA_W)) u_rport1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (beat1 & ~bus.we1),
    .rdata_i  (bus.ram_out),
    .rvalid_o (bus.rvalid1),
    .rdata_o  (bus.rdata1)
  );
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, directed corner sequences and a randomized run
// against a beat-counting ownership model with a shadow memory.
module tb_ram_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(14), .DATA_W(16)) bus ();

  ram_arbiter #(.ADDR_W(14), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_a  = '0;
  logic [15:0] pl_d  = '0;

  assign bus.ram_out = mem[bus.ram_address];
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sh [0:127];

  typedef struct {
    logic rst, r0, r1, w0, w1;
    logic [13:0] a0, a1;
    logic [15:0] d0, d1;
    logic g0, g1, ld;
    logic [13:0] ea;
    logic [15:0] ein;
    logic v0;
    logic [15:0] rd0;
    logic v1;
    logic [15:0] rd1;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [13:0] a0, input logic [13:0] a1,
                     input logic [15:0] d0, input logic [15:0] d1);
    bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
    bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [15:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    if (a < 14'd128) sh[a[6:0]] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("rst_load", {31'd0, bus.ram_load}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(logic rst, logic r0, logic r1, logic w0, logic w1,
                               logic [13:0] a0, logic [13:0] a1, logic [15:0] d0, logic [15:0] d1,
                               logic g0, logic g1, logic ld, logic [13:0] ea, logic [15:0] ein,
                               logic v0, logic [15:0] rd0, logic v1, logic [15:0] rd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.ld = ld; v.ea = ea; v.ein = ein;
    v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    return v;
  endfunction

  // Reference model state for the random run
  int          owner, last, run;
  logic        pv [2];
  logic [15:0] pd [2];
  logic        r [2], w [2];
  logic [13:0] a [2];
  logic [15:0] d [2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) preload(14'(i), 16'(16'hA000 + i));
    preload(14'h10, 16'h0000);
    preload(14'h20, 16'hBEEF);
    preload(14'h30, 16'h0000);
    for (int i = 64; i < 128; i++) preload(14'(i), 16'($urandom));

    // Vector table: write then read back, and tie-breaking after reset and after a G0 visit
    tv[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0,  14'h0,  16'h0,    16'h0, 1'b0, 1'b0, 1'b0, 14'h0,  16'h0,    1'b0, 16'h0,    1'b0, 16'h0);
    tv[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 14'h10, 14'h0,  16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, 14'h0,  16'h0,    1'b0, 16'h0,    1'b0, 16'h0);
    tv[2]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 14'h10, 14'h0,  16'h1234, 16'h0, 1'b1, 1'b0, 1'b1, 14'h10, 16'h1234, 1'b0, 16'h0,    1'b0, 16'h0);
    tv[3]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h10, 14'h0,  16'h0,    16'h0, 1'b1, 1'b0, 1'b0, 14'h10, 16'h0,    1'b0, 16'h0,    1'b0, 16'h0);
    tv[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0,  14'h0,  16'h0,    16'h0, 1'b1, 1'b0, 1'b0, 14'h0,  16'h0,    1'b1, 16'h1234, 1'b0, 16'h0);
    tv[5]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h10, 14'h20, 16'h0,    16'h0, 1'b0, 1'b0, 1'b0, 14'h0,  16'h0,    1'b0, 16'h1234, 1'b0, 16'h0);
    tv[6]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h10, 14'h20, 16'h0,    16'h0, 1'b0, 1'b1, 1'b0, 14'h20, 16'h0,    1'b0, 16'h1234, 1'b0, 16'h0);
    tv[7]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0,  14'h0,  16'h0,    16'h0, 1'b0, 1'b1, 1'b0, 14'h0,  16'h0,    1'b0, 16'h1234, 1'b1, 16'hBEEF);
    tv[8]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0,  14'h0,  16'h0,    16'h0, 1'b0, 1'b0, 1'b0, 14'h0,  16'h0,    1'b0, 16'h0,    1'b0, 16'h0);
    tv[9]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h10, 14'h20, 16'h0,    16'h0, 1'b0, 1'b0, 1'b0, 14'h0,  16'h0,    1'b0, 16'h0,    1'b0, 16'h0);
    tv[10] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h10, 14'h20, 16'h0,    16'h0, 1'b1, 1'b0, 1'b0, 14'h10, 16'h0,    1'b0, 16'h0,    1'b0, 16'h0);
    tv[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0,  14'h0,  16'h0,    16'h0, 1'b1, 1'b0, 1'b0, 14'h0,  16'h0,    1'b1, 16'h1234, 1'b0, 16'h0);
    tv[12] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0,  14'h0,  16'h0,    16'h0, 1'b0, 1'b0, 1'b0, 14'h0,  16'h0,    1'b0, 16'h1234, 1'b0, 16'h0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst_n = ~tv[i].rst;
      drv(tv[i].r0, tv[i].r1, tv[i].w0, tv[i].w1, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1);
      #1;
      chk($sformatf("vec%0d_gnt0", i), {31'd0, bus.gnt0}, {31'd0, tv[i].g0});
      chk($sformatf("vec%0d_gnt1", i), {31'd0, bus.gnt1}, {31'd0, tv[i].g1});
      chk($sformatf("vec%0d_load", i), {31'd0, bus.ram_load}, {31'd0, tv[i].ld});
      chk($sformatf("vec%0d_addr", i), {18'd0, bus.ram_address}, {18'd0, tv[i].ea});
      chk($sformatf("vec%0d_ramin", i), {16'd0, bus.ram_in}, {16'd0, tv[i].ein});
      chk($sformatf("vec%0d_rvalid0", i), {31'd0, bus.rvalid0}, {31'd0, tv[i].v0});
      chk($sformatf("vec%0d_rdata0", i), {16'd0, bus.rdata0}, {16'd0, tv[i].rd0});
      chk($sformatf("vec%0d_rvalid1", i), {31'd0, bus.rvalid1}, {31'd0, tv[i].v1});
      chk($sformatf("vec%0d_rdata1", i), {16'd0, bus.rdata1}, {16'd0, tv[i].rd1});
    end

    // Continuous contention: MAXB beats each, alternating, no gaps
    do_reset();
    for (int c = 0; c < 25; c++) begin
      int own;
      @(negedge clk);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 14'h100, 14'h200, '0, '0);
      #1;
      own = (c == 0) ? -1 : ((c - 1) / MAXB) % 2;
      chk($sformatf("burst%0d_gnt0", c), {31'd0, bus.gnt0}, (own == 0) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d_gnt1", c), {31'd0, bus.gnt1}, (own == 1) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d_addr", c), {18'd0, bus.ram_address},
          (own == 0) ? 32'h100 : (own == 1) ? 32'h200 : 32'h0);
    end

    // Lone requester 1 reading 0..9: never preempted, data one cycle late
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drv(1'b0, (c <= 10), 1'b0, 1'b0, '0, (c >= 1) ? 14'(c - 1) : 14'd0, '0, '0);
      #1;
      chk($sformatf("solo%0d_gnt1", c), {31'd0, bus.gnt1}, (c >= 1) ? 32'd1 : 32'd0);
      chk($sformatf("solo%0d_gnt0", c), {31'd0, bus.gnt0}, 32'd0);
      if (c >= 1 && c <= 10) chk($sformatf("solo%0d_addr", c), {18'd0, bus.ram_address}, 32'(c - 1));
      chk($sformatf("solo%0d_rvalid1", c), {31'd0, bus.rvalid1}, (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk($sformatf("solo%0d_rdata1", c), {16'd0, bus.rdata1}, 32'(16'hA000 + c - 2));
    end

    // Requester 0 drops while 1 waits: no beat in the drop cycle, grant moves next edge
    do_reset();
    @(negedge clk); drv(1'b1, 1'b0, 1'b1, 1'b0, 14'h11, 14'h0, 16'hCAFE, 16'h0); #1;
    chk("drop_idle_gnt0", {31'd0, bus.gnt0}, 32'd0);
    @(negedge clk); #1;
    chk("drop_g0_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("drop_g0_load", {31'd0, bus.ram_load}, 32'd1);
    @(negedge clk); drv(1'b0, 1'b1, 1'b1, 1'b1, 14'h11, 14'h22, 16'hCAFE, 16'hBBBB); #1;
    chk("drop_cyc_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("drop_cyc_load", {31'd0, bus.ram_load}, 32'd0);
    chk("drop_cyc_addr", {18'd0, bus.ram_address}, 32'd0);
    @(negedge clk); drv(1'b0, 1'b1, 1'b0, 1'b0, 14'h11, 14'h22, 16'h0, 16'h0); #1;
    chk("drop_next_gnt0", {31'd0, bus.gnt0}, 32'd0);
    chk("drop_next_gnt1", {31'd0, bus.gnt1}, 32'd1);
    chk("drop_next_addr", {18'd0, bus.ram_address}, 32'h22);
    chk("drop_mem", {16'd0, mem[14'h11]}, 32'hCAFE);

    // Reset during a G1 read burst
    do_reset();
    @(negedge clk); drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 14'h5, '0, '0);
    @(negedge clk); drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 14'h5, '0, '0); #1;
    chk("mid_g1_gnt1", {31'd0, bus.gnt1}, 32'd1);
    @(negedge clk); drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 14'h6, '0, '0); #1;
    chk("mid_rvalid1", {31'd0, bus.rvalid1}, 32'd1);
    chk("mid_rdata1", {16'd0, bus.rdata1}, 32'hA005);
    drv(1'b0, 1'b1, 1'b0, 1'b1, '0, 14'h30, '0, 16'h7777);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("mid_rst_rvalid1", {31'd0, bus.rvalid1}, 32'd0);
    chk("mid_rst_load", {31'd0, bus.ram_load}, 32'd0);
    @(negedge clk); #1;
    chk("mid_rst_nowrite", {16'd0, mem[14'h30]}, 32'd0);
    @(negedge clk); rst_n = 1'b1; drv(1'b1, 1'b1, 1'b0, 1'b0, 14'h1, 14'h2, '0, '0); #1;
    chk("mid_rel_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    @(negedge clk); #1;
    chk("mid_rel_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("mid_rel_gnt1", {31'd0, bus.gnt1}, 32'd0);
    chk("mid_rel_rvalid1", {31'd0, bus.rvalid1}, 32'd0);

    // Randomized run against the ownership model
    do_reset();
    owner = -1; last = 1; run = 0;
    pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < 1500; c++) begin
      logic beat, nv0, nv1;
      int oth;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        r[k] = ($urandom_range(0, 3) != 0);
        w[k] = $urandom_range(0, 1) != 0;
        a[k] = 14'($urandom_range(64, 127));
        d[k] = 16'($urandom);
      end
      drv(r[0], r[1], w[0], w[1], a[0], a[1], d[0], d[1]);
      #1;
      beat = (owner >= 0) && r[owner];
      chk("rnd_gnt0", {31'd0, bus.gnt0}, (owner == 0) ? 32'd1 : 32'd0);
      chk("rnd_gnt1", {31'd0, bus.gnt1}, (owner == 1) ? 32'd1 : 32'd0);
      chk("rnd_addr", {18'd0, bus.ram_address}, beat ? {18'd0, a[owner]} : 32'd0);
      chk("rnd_ramin", {16'd0, bus.ram_in}, beat ? {16'd0, d[owner]} : 32'd0);
      chk("rnd_load", {31'd0, bus.ram_load}, (beat && w[owner]) ? 32'd1 : 32'd0);
      chk("rnd_rvalid0", {31'd0, bus.rvalid0}, {31'd0, pv[0]});
      chk("rnd_rvalid1", {31'd0, bus.rvalid1}, {31'd0, pv[1]});
      chk("rnd_rdata0", {16'd0, bus.rdata0}, {16'd0, pd[0]});
      chk("rnd_rdata1", {16'd0, bus.rdata1}, {16'd0, pd[1]});
      @(posedge clk);
      nv0 = beat && owner == 0 && !w[0];
      nv1 = beat && owner == 1 && !w[1];
      if (nv0) pd[0] = sh[a[0][6:0]];
      if (nv1) pd[1] = sh[a[1][6:0]];
      pv[0] = nv0; pv[1] = nv1;
      if (beat && w[owner]) sh[a[owner][6:0]] = d[owner];
      if (owner < 0) begin
        if (r[0] && r[1]) owner = 1 - last;
        else if (r[0]) owner = 0;
        else if (r[1]) owner = 1;
        if (owner >= 0) begin last = owner; run = 0; end
      end else begin
        oth = 1 - owner;
        if (!r[owner]) begin
          if (r[oth]) begin owner = oth; last = oth; run = 0; end
          else owner = -1;
        end else begin
          run++;
          if (r[oth] && run >= MAXB) begin owner = oth; last = oth; run = 0; end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one Hack-style single-port RAM (16-bit data, 14-bit address, combinational read, write on clock edge) between two requesters: CPU data port (req 0) and screen/keyboard DMA engine (req 1).
- Round-robin arbitration with bounded bursts, a registered grant and registered read return.
- Sits between the CPU/DMA masters and the RAM16K instance in the computer top level.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 16, RAM word width.
- MAX_BURST, 4, maximum consecutive beats for one requester while the other is waiting. Minimum 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, held high while the requester wants beats.
- we0, we1  in  1  1 = write beat, 0 = read beat.
- addr0, addr1  in  ADDR_W  beat address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  registered grant; at most one high.
- rvalid0, rvalid1  out  1  read data valid, one cycle after a granted read beat.
- rdata0, rdata1  out  DATA_W  registered read data.
- ram_address  out  ADDR_W  RAM address.
- ram_in  out  DATA_W  RAM write data.
- ram_load  out  1  RAM write enable.
- ram_out  in  DATA_W  RAM combinational read data.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, gnt0/1=0, rvalid0/1=0, rdata0/1=0, beat counter=0, last_served=1 (requester 0 wins the first tie). ram_load is forced 0 while rst_n=0.
- States: IDLE, G0, G1. gntX = (state == GX).
- IDLE transitions:
  - Only reqX high -> GX.
  - Both high -> the requester != last_served.
  - Neither -> stay in IDLE.
  - No RAM access occurs in IDLE.
- A beat occurs in GX on any cycle with reqX=1. RAM outputs are combinational from state:
  - ram_address=addrX, ram_in=wdataX, ram_load=reqX&weX.
  - With no beat: ram_address=0, ram_in=0, ram_load=0.
- Read beat: at the following edge, rdataX<=ram_out and rvalidX<=1. rvalidX=0 on all other cycles. rdataX holds its value when no read occurs.
- Write beat: the RAM captures the data on the same edge. No response is returned.
- GX transitions, evaluated each edge (Y = the other requester):
  - reqX=0 -> GY if reqY, else IDLE. No beat that cycle.
  - reqX=1, reqY=1, count==MAX_BURST-1 -> beat performed, then GY.
  - Otherwise -> stay in GX, beat performed.
- Counter: cleared on every grant change; increments per beat, saturating at MAX_BURST-1. Width = clog2(MAX_BURST), minimum 1 bit.
- last_served is set to X on entry to GX.
- If reqY stays low, the burst limit does not apply: X keeps the grant indefinitely.
- A requester must present its beat only while its gnt is high; ungranted addr/wdata/we are ignored.
- Grant latency: 1 cycle from req rise in IDLE to gnt high. Handover from GX to GY: gnt switches at the edge ending X's last beat, so there are no idle cycles.
- Reset mid-burst: grant and rvalid drop immediately; any pending read return is discarded; a write on the reset edge is not performed.
- MAX_BURST=1 gives strict alternation under continuous contention.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE, G0, G1).
  - Default ADDR_W/DATA_W constants.
  - Function computing counter width.
- Sub-module ram_arb_rport, instantiated twice: per-requester read-return register (rvalid/rdata capture, async reset). All remaining logic stays in ram_arbiter.

Test Plan:
- Reset then req0=1, we0=1, addr0=0x0010, wdata0=0x1234 for 1 beat; then read 0x0010 -> gnt0 high one cycle after req0, ram_load=1 on the write beat; read gives rvalid0=1 with rdata0=0x1234 one cycle after the read beat.
- req0 and req1 rise in the same cycle from IDLE after reset -> gnt0 first; the next contention tie from IDLE grants req1.
- Both held high continuously, MAX_BURST=4 -> grant pattern is 4 beats G0, 4 beats G1, repeating; ram_address tracks the granted requester; no gap cycles.
- req1 alone held for 10 beats, reading addresses 0..9 preloaded with 0xA000+i -> gnt1 stays high, no preemption; rvalid1/rdata1 return 0xA000..0xA009 in order, each one cycle late.
- In G0, req0 drops while req1 is high -> next edge gnt1=1, gnt0=0; ram_load stays 0 in the drop cycle.
- rst_n pulled low mid-burst during a G1 read -> gnt1, rvalid1 and ram_load go 0 immediately; after release, IDLE and req0 wins the tie.
